// File: rtl/serial_tx_if.sv
// Handshake and serial-line bundle for the serial_tx block.
// The producer side holds the master modport; the transmitter holds the slave modport.
interface serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_out;
  logic              busy;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_out,
    input  busy
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_out,
    output busy
  );
endinterface

// File: rtl/serial_tx.sv
// Serial transmitter: start bit (0), DATA_W data bits LSB first, stop bit (1).
// Each bit lasts CLKS_PER_BIT clocks; all outputs come straight from flops.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        rstb,
  serial_tx_if.slave  tx_if
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  if ((DATA_W < 1) || (DATA_W > 16)) begin : g_bad_data_w
    $error("serial_tx: DATA_W must be in 1..16");
  end
  if ((CLKS_PER_BIT < 1) || (CLKS_PER_BIT > 255)) begin : g_bad_clks
    $error("serial_tx: CLKS_PER_BIT must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_out_q, tx_out_d;
  logic              tx_ready_q, tx_ready_d;
  logic              busy_q, busy_d;

  logic              accept;
  logic              bit_done;
  logic [DATA_W-1:0] shift_next;

  assign accept     = tx_if.tx_valid & tx_ready_q;
  assign bit_done   = (cnt_q == CNT_LAST);
  assign shift_next = shift_q >> 1;

  // The next line level is decided at the same edge the state changes,
  // so tx_out is already correct in the first cycle of every bit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = bit_done ? '0 : cnt_q + 1'b1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    tx_out_d   = tx_out_q;
    tx_ready_d = tx_ready_q;
    busy_d     = busy_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (accept) begin
          shift_d    = tx_if.tx_data;
          state_d    = START;
          tx_out_d   = 1'b0;
          tx_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end

      START: begin
        if (bit_done) begin
          state_d  = DATA;
          bit_d    = '0;
          tx_out_d = shift_q[0];
        end
      end

      DATA: begin
        if (bit_done) begin
          if (bit_q == IDX_LAST) begin
            state_d  = STOP;
            tx_out_d = 1'b1;
          end else begin
            bit_d    = bit_q + 1'b1;
            shift_d  = shift_next;
            tx_out_d = shift_next[0];
          end
        end
      end

      STOP: begin
        if (bit_done) begin
          state_d    = IDLE;
          tx_ready_d = 1'b1;
          busy_d     = 1'b0;
          tx_out_d   = 1'b1;
        end
      end

      default: begin
        state_d    = IDLE;
        cnt_d      = '0;
        bit_d      = '0;
        tx_out_d   = 1'b1;
        tx_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
    endcase
  end

  // Synchronous reset wins over acceptance and aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_out_q   <= 1'b1;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_out_q   <= tx_out_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_if.tx_out   = tx_out_q;
  assign tx_if.tx_ready = tx_ready_q;
  assign tx_if.busy     = busy_q;

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: frame-level reference model compared every cycle,
// literal waveform checks for the documented scenarios, and a DATA_W=1/CLKS_PER_BIT=1 corner.
module tb_serial_tx;

  localparam int DW    = 8;
  localparam int CPB   = 4;
  localparam int FRAME = (DW + 2) * CPB;

  logic clk;
  logic rstb;

  int pass_cnt  = 0;
  int total_cnt = 0;

  serial_tx_if #(.DATA_W(DW)) bus ();
  serial_tx_if #(.DATA_W(1))  bus2 ();

  serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rstb  (rstb),
    .tx_if (bus)
  );

  serial_tx #(.DATA_W(1), .CLKS_PER_BIT(1)) dut2 (
    .clk   (clk),
    .rstb  (rstb),
    .tx_if (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic checkWave(input string name, input logic [FRAME-1:0] actual,
                           input logic [FRAME-1:0] expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Reference model: a frame is just the bit list {start, data LSB first, stop},
  // each bit lasting CPB cycles after the acceptance edge.
  int          cycle      = 0;
  bit          checking   = 0;
  bit          m_busy     = 0;
  int          m_start    = 0;
  logic [DW-1:0] m_word   = '0;
  int          accepts    = 0;
  logic        prev_busy  = 1'b0;
  int          busy_rise_q[$];

  function automatic logic frameBit(input logic [DW-1:0] word, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DW) return word[idx-1];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    logic s_rstb;
    logic s_valid;
    logic [DW-1:0] s_data;
    logic exp_out;
    s_rstb  = rstb;
    s_valid = bus.tx_valid;
    s_data  = bus.tx_data;
    cycle++;
    if (!s_rstb) begin
      m_busy   = 0;
      checking = 1;
    end else if (m_busy) begin
      if (cycle - m_start == FRAME) m_busy = 0;
    end else if (s_valid) begin
      m_busy  = 1;
      m_start = cycle;
      m_word  = s_data;
      accepts++;
    end
    #1;
    if (checking) begin
      exp_out = m_busy ? frameBit(m_word, (cycle - m_start) / CPB) : 1'b1;
      checkOutput($sformatf("tx_out@%0d", cycle), int'(bus.tx_out), int'(exp_out));
      checkOutput($sformatf("tx_ready@%0d", cycle), int'(bus.tx_ready), int'(!m_busy));
      checkOutput($sformatf("busy@%0d", cycle), int'(bus.busy), int'(m_busy));
      if (bus.busy === 1'b1 && prev_busy !== 1'b1) busy_rise_q.push_back(cycle);
      prev_busy = bus.busy;
    end
  end

  // Drives a word and returns at the negedge right after the acceptance edge.
  task automatic applyStimulus(input logic [DW-1:0] data, input bit hold);
    int n;
    bit got;
    @(negedge clk);
    bus.tx_data  = data;
    bus.tx_valid = 1'b1;
    n   = accepts;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (accepts != n) begin
        got = 1;
        break;
      end
    end
    if (!got) checkOutput("accept_timeout", 0, 1);
    if (!hold) bus.tx_valid = 1'b0;
  endtask

  task automatic waitIdle();
    bit done;
    done = 0;
    for (int i = 0; i < 200; i++) begin
      if (!m_busy) begin
        done = 1;
        break;
      end
      @(negedge clk);
    end
    if (!done) checkOutput("idle_timeout", 0, 1);
  endtask

  // Samples tx_out for the whole frame starting at the current negedge (cycle 0).
  task automatic captureFrame(output logic [FRAME-1:0] wave, output logic rdy_last,
                              output logic rdy_after);
    wave = '0;
    for (int k = 0; k < FRAME; k++) begin
      if (k != 0) @(negedge clk);
      wave[k] = bus.tx_out;
      if (k == FRAME - 1) rdy_last = bus.tx_ready;
    end
    @(negedge clk);
    rdy_after = bus.tx_ready;
  endtask

  function automatic logic [FRAME-1:0] expandSeq(input int seq[10]);
    logic [FRAME-1:0] w;
    for (int k = 0; k < FRAME; k++) w[k] = seq[k / CPB][0];
    return w;
  endfunction

  task automatic resetPulse(input int cycles);
    @(negedge clk);
    rstb = 1'b0;
    repeat (cycles) @(negedge clk);
    rstb = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [FRAME-1:0] wave;
    logic rdy_last, rdy_after;
    int seq_a5[10] = '{0,1,0,1,0,0,1,0,1,1};
    int seq_5a[10] = '{0,0,1,0,1,1,0,1,0,1};
    int seq_81[10] = '{0,1,0,0,0,0,0,0,1,1};
    int zeros, first_one, n0;

    rstb          = 1'b0;
    bus.tx_valid  = 1'b0;
    bus.tx_data   = '0;
    bus2.tx_valid = 1'b0;
    bus2.tx_data  = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_tx_out", int'(bus.tx_out), 1);
    checkOutput("reset_tx_ready", int'(bus.tx_ready), 1);
    checkOutput("reset_busy", int'(bus.busy), 0);
    rstb = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_hold_tx_out", int'(bus.tx_out), 1);

    // Corner instance: one data bit, one clock per bit.
    for (int v = 1; v >= 0; v--) begin
      bus2.tx_data  = v[0];
      bus2.tx_valid = 1'b1;
      @(negedge clk);
      bus2.tx_valid = 1'b0;
      checkOutput($sformatf("c1_start_out_%0d", v), int'(bus2.tx_out), 0);
      checkOutput($sformatf("c1_start_ready_%0d", v), int'(bus2.tx_ready), 0);
      @(negedge clk);
      checkOutput($sformatf("c1_data_out_%0d", v), int'(bus2.tx_out), v);
      @(negedge clk);
      checkOutput($sformatf("c1_stop_out_%0d", v), int'(bus2.tx_out), 1);
      checkOutput($sformatf("c1_stop_busy_%0d", v), int'(bus2.busy), 1);
      @(negedge clk);
      checkOutput($sformatf("c1_idle_ready_%0d", v), int'(bus2.tx_ready), 1);
      checkOutput($sformatf("c1_idle_busy_%0d", v), int'(bus2.busy), 0);
      @(negedge clk);
    end

    applyStimulus(8'hA5, 1'b0);
    captureFrame(wave, rdy_last, rdy_after);
    checkWave("frame_a5", wave, expandSeq(seq_a5));
    checkOutput("a5_ready_before_end", int'(rdy_last), 0);
    checkOutput("a5_ready_at_edge40", int'(rdy_after), 1);

    applyStimulus(8'h00, 1'b0);
    captureFrame(wave, rdy_last, rdy_after);
    zeros = 0;
    first_one = FRAME;
    for (int k = FRAME - 1; k >= 0; k--) begin
      if (wave[k] == 1'b0) zeros++;
      else first_one = k;
    end
    checkOutput("x00_low_cycles", zeros, 36);
    checkOutput("x00_first_high", first_one, 36);

    applyStimulus(8'hFF, 1'b0);
    captureFrame(wave, rdy_last, rdy_after);
    zeros = 0;
    first_one = FRAME;
    for (int k = FRAME - 1; k >= 0; k--) begin
      if (wave[k] == 1'b0) zeros++;
      else first_one = k;
    end
    checkOutput("xff_low_cycles", zeros, 4);
    checkOutput("xff_first_high", first_one, 4);

    repeat (2) @(negedge clk);
    n0 = busy_rise_q.size();
    applyStimulus(8'h3C, 1'b1);
    repeat (20) @(negedge clk);
    bus.tx_data = 8'hC3;
    applyStimulus(8'hC3, 1'b0);
    checkOutput("b2b_rises", busy_rise_q.size() - n0, 2);
    if (busy_rise_q.size() >= n0 + 2)
      checkOutput("b2b_spacing", busy_rise_q[n0+1] - busy_rise_q[n0], FRAME + 1);
    waitIdle();

    @(negedge clk);
    applyStimulus(8'h5A, 1'b0);
    for (int k = 0; k < FRAME; k++) begin
      if (k != 0) @(negedge clk);
      wave[k] = bus.tx_out;
      if (k == 10) begin
        bus.tx_data  = 8'hFF;
        bus.tx_valid = 1'b1;
      end
      if (k == 14) bus.tx_valid = 1'b0;
    end
    checkWave("frame_5a_disturbed", wave, expandSeq(seq_5a));
    waitIdle();

    applyStimulus(8'hC5, 1'b0);
    repeat (14) @(negedge clk);
    rstb = 1'b0;
    @(negedge clk);
    checkOutput("midrst_tx_out", int'(bus.tx_out), 1);
    checkOutput("midrst_tx_ready", int'(bus.tx_ready), 1);
    checkOutput("midrst_busy", int'(bus.busy), 0);
    @(negedge clk);
    rstb = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_rst_line", int'(bus.tx_out), 1);
    applyStimulus(8'h81, 1'b0);
    captureFrame(wave, rdy_last, rdy_after);
    checkWave("frame_81_after_reset", wave, expandSeq(seq_81));

    // Randomized traffic: gaps, held valid, mid-frame data churn and aborts.
    for (int it = 0; it < 16; it++) begin
      bit hold;
      int when;
      hold = ($urandom_range(0, 2) == 0);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      applyStimulus(DW'($urandom), hold);
      when = $urandom_range(1, FRAME - 2);
      repeat (when) @(negedge clk);
      bus.tx_data = DW'($urandom);
      if ($urandom_range(0, 3) == 0) resetPulse($urandom_range(1, 2));
      if (!hold) waitIdle();
    end
    bus.tx_valid = 1'b0;
    waitIdle();
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits; legal range 1..16.
REQ-002 Parameter CLKS_PER_BIT, default 4, clk cycles per serial bit; legal range 1..255.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rstb  input  1  reset, synchronous, active-low.
REQ-005 tx_data  input  DATA_W  parallel word to transmit; sampled only at acceptance.
REQ-006 tx_valid  input  1  producer requests transmission of tx_data.
REQ-007 tx_ready  output  1  block can accept a word; registered.
REQ-008 tx_out  output  1  serial line; idles high; registered.
REQ-009 busy  output  1  frame in progress; registered.

Function
REQ-010 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-011 Acceptance SHALL occur at a rising edge where tx_valid=1 and tx_ready=1; tx_data is then latched into an internal shift register.
REQ-012 tx_ready SHALL be 1 only in IDLE; at the acceptance edge: state->START, tx_ready<-0, busy<-1, tx_out<-0.
REQ-013 START SHALL hold tx_out=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
REQ-014 DATA SHALL send DATA_W bits, LSB first, each held for exactly CLKS_PER_BIT cycles.
REQ-015 After the last data bit, the FSM SHALL go to STOP and hold tx_out=1 for exactly CLKS_PER_BIT cycles.
REQ-016 At the edge ending STOP: state->IDLE, tx_ready<-1, busy<-0, tx_out stays 1.
REQ-017 The frame SHALL last (DATA_W+2)*CLKS_PER_BIT cycles, counted from the acceptance edge to the return-to-IDLE edge.
REQ-018 The minimum spacing between successive acceptance edges SHALL be (DATA_W+2)*CLKS_PER_BIT+1 cycles: tx_ready must be high for at least one sampled edge.
REQ-019 The bit-period counter SHALL be ceil(log2(CLKS_PER_BIT+1)) bits wide, count 0..CLKS_PER_BIT-1, and reload to 0 at each bit boundary with no wrap glitch.
REQ-020 The bit index counter SHALL count 0..DATA_W-1 and reset to 0 on entry to DATA.
REQ-021 With CLKS_PER_BIT=1, the block SHALL still produce one cycle per bit with no skipped or duplicated bits.
REQ-022 Changes on tx_data or tx_valid while busy=1 SHALL NOT affect the frame in flight.
REQ-023 tx_valid held high continuously SHALL send the held word repeatedly, at the REQ-018 spacing.
REQ-024 In IDLE with tx_valid=0, all outputs SHALL hold: tx_out=1, tx_ready=1, busy=0.

Reset
REQ-025 At a rising edge with rstb=0: state<-IDLE, tx_out<-1, tx_ready<-1, busy<-0, all counters and the shift register <-0.
REQ-026 Reset SHALL take priority over acceptance and over any in-flight frame.
REQ-027 A reset asserted mid-frame SHALL abort the frame. The line returns high at that edge, and no partial bits resume after rstb deasserts.
REQ-028 No output SHALL change between clock edges, including on rstb transitions.

Verification (DATA_W=8, CLKS_PER_BIT=4)
REQ-029 Single word: send 8'hA5 -> tx_out bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, 40 cycles total; tx_ready returns to 1 at edge 40 after acceptance.
REQ-030 Extremes: send 8'h00 -> tx_out low for 36 cycles, then high for 4; send 8'hFF -> tx_out low for 4 cycles, then high for 36.
REQ-031 Back-to-back: tx_valid held high with 8'h3C then 8'hC3 -> acceptance edges exactly 41 cycles apart; both frames are bit-exact.
REQ-032 Mid-frame disturbance: change tx_data to 8'hFF and drop tx_valid during the DATA state of frame 8'h5A -> the frame still serializes 8'h5A.
REQ-033 Reset mid-frame: assert rstb=0 for 2 cycles at cycle 15 of a frame -> tx_out=1, tx_ready=1, busy=0 from the reset edge on; the next accepted 8'h81 frame is bit-exact.
REQ-034 Parameter corner: CLKS_PER_BIT=1, DATA_W=1; send 1'b1 -> tx_out sequence 0,1,1, one cycle each, 3-cycle frame.
